// File: rtl/magic_nor_sequencer.sv
// magic_nor_sequencer: steps a stored list of MAGIC NOR / inverter gates through a
// memristive crossbar. Each gate is a FETCH, then an INIT and an EVAL phase, each
// closed by xbar_ack. All outputs are registered.
// Optional feature: define MAGIC_HAZARD_CHECK_EN to abort on a gate whose output
// column aliases one of its input columns (sets sticky err, no done pulse).
module magic_nor_sequencer #(
  parameter int unsigned COL_W      = 5,
  parameter int unsigned PROG_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             prog_we,
  input  logic [3:0]       prog_addr,
  input  logic [15:0]      prog_data,
  input  logic [4:0]       prog_len,
  input  logic             start,
  input  logic             xbar_ack,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             xbar_init,
  output logic             xbar_eval,
  output logic             xbar_inv,
  output logic [COL_W-1:0] xbar_col_a,
  output logic [COL_W-1:0] xbar_col_b,
  output logic [COL_W-1:0] xbar_col_d,
  output logic [3:0]       gate_idx
);

  typedef enum logic [2:0] {StIdle, StFetch, StInit, StEval, StDone} state_e;

  state_e           state_q;
  logic [15:0]      mem_q [PROG_DEPTH];
  logic [15:0]      op_q;
  logic [3:0]       pc_q;
  logic [4:0]       len_q;
  logic             busy_q, done_q, init_q, eval_q, inv_q;
  logic [COL_W-1:0] col_a_q, col_b_q, col_d_q;

  logic [15:0]      fetch_word;
  logic [4:0]       len_clamp;
  logic             last_gate;

  assign fetch_word = mem_q[pc_q];
  assign len_clamp  = (prog_len > 5'(PROG_DEPTH)) ? 5'(PROG_DEPTH) : prog_len;
  assign last_gate  = ({1'b0, pc_q} == (len_q - 5'd1));

`ifdef MAGIC_HAZARD_CHECK_EN
  logic hazard;
  logic err_q;
  // Output column must not alias an input column that the gate actually reads.
  assign hazard = (fetch_word[4:0] == fetch_word[14:10]) ||
                  (fetch_word[15] && (fetch_word[4:0] == fetch_word[9:5]));
  assign err    = err_q;
`else
  assign err    = 1'b0;
`endif

  // Program store; deliberately has no reset so the program survives rst_n.
  always_ff @(posedge clk) begin
    if (prog_we && !busy_q && (32'(prog_addr) < PROG_DEPTH)) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Sequencer FSM with registered crossbar/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= '0;
      len_q   <= '0;
      op_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      init_q  <= 1'b0;
      eval_q  <= 1'b0;
      inv_q   <= 1'b0;
      col_a_q <= '0;
      col_b_q <= '0;
      col_d_q <= '0;
`ifdef MAGIC_HAZARD_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
`ifdef MAGIC_HAZARD_CHECK_EN
            err_q <= 1'b0;
`endif
            len_q <= len_clamp;
            pc_q  <= '0;
            if (len_clamp == 5'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StFetch;
              busy_q  <= 1'b1;
            end
          end
        end
        StFetch: begin
          op_q    <= fetch_word;
          state_q <= StInit;
          init_q  <= 1'b1;
          col_d_q <= COL_W'(fetch_word[4:0]);
`ifdef MAGIC_HAZARD_CHECK_EN
          // Later assignments override the INIT setup above.
          if (hazard) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            init_q  <= 1'b0;
            col_d_q <= '0;
            state_q <= StIdle;
          end
`endif
        end
        StInit: begin
          if (xbar_ack) begin
            state_q <= StEval;
            init_q  <= 1'b0;
            eval_q  <= 1'b1;
            inv_q   <= ~op_q[15];
            col_a_q <= COL_W'(op_q[14:10]);
            // inv1 drives both inputs from the same column.
            col_b_q <= op_q[15] ? COL_W'(op_q[9:5]) : COL_W'(op_q[14:10]);
          end
        end
        StEval: begin
          if (xbar_ack) begin
            eval_q  <= 1'b0;
            inv_q   <= 1'b0;
            col_a_q <= '0;
            col_b_q <= '0;
            col_d_q <= '0;
            if (last_gate) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pc_q    <= pc_q + 4'd1;
              state_q <= StFetch;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign xbar_init  = init_q;
  assign xbar_eval  = eval_q;
  assign xbar_inv   = inv_q;
  assign xbar_col_a = col_a_q;
  assign xbar_col_b = col_b_q;
  assign xbar_col_d = col_d_q;
  assign gate_idx   = pc_q;

endmodule

// File: tb/tb_magic_nor_sequencer.sv
// Directed bench for magic_nor_sequencer. Outputs are sampled 1 time unit after
// each rising edge and packed into one vector for comparison.
module tb_magic_nor_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [4:0]  prog_len = '0;
  logic        start = 1'b0;
  logic        xbar_ack = 1'b0;
  logic        busy, done, err, xbar_init, xbar_eval, xbar_inv;
  logic [4:0]  xbar_col_a, xbar_col_b, xbar_col_d;
  logic [3:0]  gate_idx;

  int n_cmp = 0;
  int n_fail = 0;

  magic_nor_sequencer #(.COL_W(5), .PROG_DEPTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_len   (prog_len),
    .start      (start),
    .xbar_ack   (xbar_ack),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .xbar_init  (xbar_init),
    .xbar_eval  (xbar_eval),
    .xbar_inv   (xbar_inv),
    .xbar_col_a (xbar_col_a),
    .xbar_col_b (xbar_col_b),
    .xbar_col_d (xbar_col_d),
    .gate_idx   (gate_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  // {busy, done, init, eval, inv, col_a, col_b, col_d, gate_idx, err}
  function automatic logic [24:0] v(input logic b, input logic d, input logic i,
                                    input logic e, input logic inv, input logic [4:0] ca,
                                    input logic [4:0] cb, input logic [4:0] cd,
                                    input logic [3:0] idx, input logic er);
    return {b, d, i, e, inv, ca, cb, cd, idx, er};
  endfunction

  function automatic logic [24:0] obs();
    return v(busy, done, xbar_init, xbar_eval, xbar_inv, xbar_col_a, xbar_col_b,
             xbar_col_d, gate_idx, err);
  endfunction

  // Slot 0 is inv1 a=1 d=6; slot i>0 is nor2 a=i b=i+1 d=i+16 (never hazardous).
  function automatic logic [15:0] slot_word(input int i);
    if (i == 0) return 16'h0426;
    return {1'b1, 5'(i), 5'(i + 1), 5'(i + 16)};
  endfunction

  function automatic logic [24:0] exp_fetch(input int g);
    return v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 4'(g), 1'b0);
  endfunction

  function automatic logic [24:0] exp_init(input int g);
    logic [15:0] w = slot_word(g);
    return v(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, w[4:0], 4'(g), 1'b0);
  endfunction

  function automatic logic [24:0] exp_eval(input int g);
    logic [15:0] w = slot_word(g);
    logic [4:0]  b = w[15] ? w[9:5] : w[14:10];
    return v(1'b1, 1'b0, 1'b0, 1'b1, ~w[15], w[14:10], b, w[4:0], 4'(g), 1'b0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input int i, input logic [15:0] w);
    prog_we   = 1'b1;
    prog_addr = 4'(i);
    prog_data = w;
    tick();
    prog_we   = 1'b0;
  endtask

  // Leaves the bench just after the edge that samples start (edge 0).
  task automatic start_run(input logic [4:0] len);
    prog_len = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // 16-gate run with ack tied high; checks every cycle from edge 0 to edge 49.
  // done is expected only after edge 48, i.e. 49 cycles counting the start cycle.
  task automatic run_full_check(input string name);
    logic [24:0] e;
    xbar_ack = 1'b1;
    start_run(5'd16);
    for (int k = 0; k <= 49; k++) begin
      if (k > 0) tick();
      if (k == 0) e = exp_fetch(0);
      else if (k == 49) e = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd15, 1'b0);
      else begin
        int g = (k - 1) / 3;
        int ph = (k - 1) % 3;
        if (ph == 0) e = exp_init(g);
        else if (ph == 1) e = exp_eval(g);
        else if (g < 15) e = exp_fetch(g + 1);
        else e = v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd15, 1'b0);
      end
      n_cmp++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL %s edge %0d: got %h required %h", name, k, obs(), e);
      end
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++;
    if (obs() !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %h required %h", obs(), 25'd0);
    end
    rst_n    = 1'b1;
    xbar_ack = 1'b1;  // must be ignored in IDLE
    tick();
    tick();
    tick();
    n_cmp++;
    if (obs() !== 25'd0) begin
      n_fail++;
      $display("FAIL idle_after_release: got %h required %h", obs(), 25'd0);
    end
    xbar_ack = 1'b0;
  endtask

  task automatic load_program();
    for (int i = 0; i < 16; i++) write_slot(i, slot_word(i));
  endtask

  task automatic test_inv1();
    logic [24:0] e [4];
    e[0] = v(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd6, 4'd0, 1'b0);
    e[1] = v(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd1, 5'd6, 4'd0, 1'b0);
    e[2] = v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0);
    e[3] = 25'd0;
    xbar_ack = 1'b1;
    start_run(5'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++;
      if (obs() !== e[k]) begin
        n_fail++;
        $display("FAIL inv1 edge %0d: got %h required %h", k + 1, obs(), e[k]);
      end
    end
  endtask

  task automatic test_full_program();
    run_full_check("full16");
  endtask

  task automatic test_ack_stall();
    logic [24:0] ei;
    ei = v(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd6, 4'd0, 1'b0);
    xbar_ack = 1'b0;
    start_run(5'd1);
    xbar_ack = 1'b1;  // during FETCH; must be ignored there
    for (int k = 1; k <= 6; k++) begin
      tick();
      xbar_ack = (k == 6);
      n_cmp++;
      if (obs() !== ei) begin
        n_fail++;
        $display("FAIL stall_init edge %0d: got %h required %h", k, obs(), ei);
      end
    end
    tick();
    n_cmp++;
    if (obs() !== v(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd1, 5'd6, 4'd0, 1'b0)) begin
      n_fail++;
      $display("FAIL stall_eval: got %h required eval of slot 0", obs());
    end
    tick();
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_done: got %b required 1", done);
    end
    tick();
  endtask

  task automatic test_len_zero();
    xbar_ack = 1'b1;
    start_run(5'd0);
    n_cmp++;
    if (obs() !== v(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0)) begin
      n_fail++;
      $display("FAIL len0_done: got %h required done only", obs());
    end
    tick();
    n_cmp++;
    if (obs() !== 25'd0) begin
      n_fail++;
      $display("FAIL len0_idle: got %h required %h", obs(), 25'd0);
    end
  endtask

  task automatic test_len_clamp();
    int e = 0;
    xbar_ack = 1'b1;
    start_run(5'd20);
    while (!done && e < 200) begin
      tick();
      e++;
    end
    n_cmp++;
    if (e != 48) begin
      n_fail++;
      $display("FAIL len_clamp_done_edge: got %0d required 48", e);
    end
    tick();
  endtask

  task automatic test_busy_ignore();
    int e = 0;
    xbar_ack = 1'b1;
    start_run(5'd16);
    tick();
    e++;
    prog_we   = 1'b1;
    prog_addr = 4'd3;
    prog_data = 16'hFFFF;
    prog_len  = 5'd0;
    start     = 1'b1;
    tick();
    tick();
    e += 2;
    prog_we = 1'b0;
    start   = 1'b0;
    while (!done && e < 200) begin
      tick();
      e++;
    end
    n_cmp++;
    if (e != 48) begin
      n_fail++;
      $display("FAIL busy_start_ignored: got done at edge %0d required 48", e);
    end
    prog_len = 5'd1;
    start    = 1'b1;  // lands in DONE; must be ignored
    tick();
    start    = 1'b0;
    tick();
    n_cmp++;
    if (obs() !== v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd15, 1'b0)) begin
      n_fail++;
      $display("FAIL done_start_ignored: got %h required idle", obs());
    end
    run_full_check("prog_intact_after_busy_write");
  endtask

  task automatic test_reset_mid();
    xbar_ack = 1'b1;
    start_run(5'd16);
    for (int k = 1; k <= 23; k++) tick();
    n_cmp++;
    if (obs() !== exp_eval(7)) begin
      n_fail++;
      $display("FAIL pre_reset_eval7: got %h required %h", obs(), exp_eval(7));
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 25'd0) begin
      n_fail++;
      $display("FAIL async_reset_mid: got %h required %h", obs(), 25'd0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (obs() !== 25'd0) begin
      n_fail++;
      $display("FAIL no_restart_after_reset: got %h required %h", obs(), 25'd0);
    end
    run_full_check("rerun_after_reset");
  endtask

`ifdef MAGIC_HAZARD_CHECK_EN
  task automatic test_hazard();
    logic [24:0] eh;
    eh = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 4'd2, 1'b1);
    write_slot(2, 16'h8C83);
    xbar_ack = 1'b1;
    start_run(5'd16);
    for (int k = 1; k <= 7; k++) tick();
    n_cmp++;
    if (obs() !== eh) begin
      n_fail++;
      $display("FAIL hazard_abort: got %h required %h", obs(), eh);
    end
    for (int k = 0; k < 5; k++) tick();
    n_cmp++;
    if (obs() !== eh) begin
      n_fail++;
      $display("FAIL hazard_sticky: got %h required %h", obs(), eh);
    end
    write_slot(2, slot_word(2));
    start_run(5'd1);
    n_cmp++;
    if (obs() !== exp_fetch(0)) begin
      n_fail++;
      $display("FAIL hazard_err_clear: got %h required %h", obs(), exp_fetch(0));
    end
    for (int k = 0; k < 4; k++) tick();
  endtask
`endif

  initial begin
    test_reset();
    load_program();
    test_inv1();
    test_full_program();
    test_ack_stall();
    test_len_zero();
    test_len_clamp();
    test_busy_ignore();
    test_reset_mid();
`ifdef MAGIC_HAZARD_CHECK_EN
    test_hazard();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
